aes_round_mix: RTL and testbench

Registered AES round back-end that consumes the 128-bit state produced by the SubBytes stage and applies ShiftRows, MixColumns (skipped on the final round) and AddRoundKey. It turns the combinational SubBytes output into one pipelined, flow-controlled round step. Throughput is one state per cycle. A two-entry output buffer keeps `in_ready` registered so that backpressure never combinationally reaches the SubBytes side.

---
 rtl/aes_round_mix.sv | 137 +++++++++++++
 tb/tb_aes_round_mix.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_mix.sv
// AES round back-end: ShiftRows -> MixColumns (skipped on final round) -> AddRoundKey, 1-cycle latency.
// Main register plus one skid entry; in_ready is a flop (!skid valid), so out_ready never reaches it combinationally.
`timescale 1ns/1ps
module aes_round_mix #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_state,
    input  logic [127:0]     in_key,
    input  logic             in_last,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_state,
    output logic [TAG_W-1:0] out_tag
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One column, row 0 in the most significant byte.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    logic [127:0]     w_sr;
    logic [127:0]     w_mc;
    logic [127:0]     w_result;
    logic             w_in_xfer;
    logic             w_out_xfer;

    logic             r_main_vld;
    logic [127:0]     r_main_dat;
    logic [TAG_W-1:0] r_main_tag;
    logic             r_skid_vld;
    logic [127:0]     r_skid_dat;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_in_rdy;

    logic             w_main_vld_nxt;
    logic [127:0]     w_main_dat_nxt;
    logic [TAG_W-1:0] w_main_tag_nxt;
    logic             w_skid_vld_nxt;
    logic [127:0]     w_skid_dat_nxt;
    logic [TAG_W-1:0] w_skid_tag_nxt;

    // Byte (r,c) lives at bits [127-8*(4c+r) -: 8].
    always_comb begin
        w_sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[127-8*(4*c+r) -: 8] = in_state[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

    always_comb begin
        w_mc = '0;
        for (int c = 0; c < 4; c++) begin
            w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
        end
    end

    assign w_result   = (in_last ? w_sr : w_mc) ^ in_key;
    assign w_in_xfer  = in_valid && r_in_rdy;
    assign w_out_xfer = r_main_vld && out_ready;

    // An input transfer implies the skid is empty, so the two updates never collide on the skid.
    always_comb begin
        w_main_vld_nxt = r_main_vld;
        w_main_dat_nxt = r_main_dat;
        w_main_tag_nxt = r_main_tag;
        w_skid_vld_nxt = r_skid_vld;
        w_skid_dat_nxt = r_skid_dat;
        w_skid_tag_nxt = r_skid_tag;
        if (w_out_xfer) begin
            if (r_skid_vld) begin
                w_main_dat_nxt = r_skid_dat;
                w_main_tag_nxt = r_skid_tag;
                w_skid_vld_nxt = 1'b0;
            end else begin
                w_main_vld_nxt = 1'b0;
            end
        end
        if (w_in_xfer) begin
            if (!r_main_vld || w_out_xfer) begin
                w_main_vld_nxt = 1'b1;
                w_main_dat_nxt = w_result;
                w_main_tag_nxt = in_tag;
            end else begin
                w_skid_vld_nxt = 1'b1;
                w_skid_dat_nxt = w_result;
                w_skid_tag_nxt = in_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_vld <= 1'b0;
            r_main_dat <= '0;
            r_main_tag <= '0;
            r_skid_vld <= 1'b0;
            r_skid_dat <= '0;
            r_skid_tag <= '0;
            r_in_rdy   <= 1'b1;
        end else begin
            r_main_vld <= w_main_vld_nxt;
            r_main_dat <= w_main_dat_nxt;
            r_main_tag <= w_main_tag_nxt;
            r_skid_vld <= w_skid_vld_nxt;
            r_skid_dat <= w_skid_dat_nxt;
            r_skid_tag <= w_skid_tag_nxt;
            r_in_rdy   <= !w_skid_vld_nxt;
        end
    end

    assign in_ready  = r_in_rdy;
    assign out_valid = r_main_vld;
    assign out_state = r_main_dat;
    assign out_tag   = r_main_tag;

endmodule

// File: tb/tb_aes_round_mix.sv
// Bench for aes_round_mix: directed vectors, backpressure, streaming and reset,
// with a negedge scoreboard fed by an independent AES round model.
`timescale 1ns/1ps
module tb_aes_round_mix;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [127:0]     in_state = '0;
    logic [127:0]     in_key = '0;
    logic             in_last = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [127:0]     out_state;
    logic [TAG_W-1:0] out_tag;

    int checks = 0;
    int errors = 0;

    logic [127:0]     sb_dat[$];
    logic [TAG_W-1:0] sb_tag[$];

    aes_round_mix #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_key(in_key), .in_last(in_last), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? (8'(x << 1) ^ 8'h1b) : 8'(x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] coef(input int d);
        case (d)
            0: return 8'h02;
            1: return 8'h03;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic last);
        logic [7:0]   s[4][4];
        logic [7:0]   t[4][4];
        logic [7:0]   m;
        logic [127:0] res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = st[127-8*(4*c+r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r][c] = s[r][(c+r)%4];
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (last) begin
                    m = t[r][c];
                end else begin
                    m = 8'h00;
                    for (int k = 0; k < 4; k++) m = m ^ gmul(coef((k - r + 4) % 4), t[k][c]);
                end
                res[127-8*(4*c+r) -: 8] = m;
            end
        end
        return res ^ key;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboard: push model result on accepted input, pop and compare on accepted output.
    always @(negedge clk) begin
        if (rst) begin
            sb_dat.delete();
            sb_tag.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb_dat.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: output tag=%0h state=%h with nothing expected", out_tag, out_state);
                end else begin
                    logic [127:0]     ed;
                    logic [TAG_W-1:0] et;
                    ed = sb_dat.pop_front();
                    et = sb_tag.pop_front();
                    if (out_state !== ed || out_tag !== et) begin
                        errors++;
                        $display("FAIL sb_order: got tag=%0h state=%h, expected tag=%0h state=%h",
                                 out_tag, out_state, et, ed);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb_dat.push_back(ref_round(in_state, in_key, in_last));
                sb_tag.push_back(in_tag);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (out_state !== 128'h0) begin errors++; $display("FAIL reset_out_state: got %h want 0", out_state); end
        checks++;
        if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic send_one(input logic [127:0] st, input logic [127:0] key, input logic last,
                            input logic [TAG_W-1:0] tag, input logic [127:0] exp_state, input string name);
        out_ready = 1'b1;
        in_state  = st;
        in_key    = key;
        in_last   = last;
        in_tag    = tag;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b want 1", name, out_valid); end
        checks++;
        if (out_state !== exp_state) begin errors++; $display("FAIL %s_state: got %h want %h", name, out_state, exp_state); end
        checks++;
        if (out_tag !== tag) begin errors++; $display("FAIL %s_tag: got %h want %h", name, out_tag, tag); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain: out_valid got %b want 0", name, out_valid); end
    endtask

    task automatic test_fips_round();
        send_one(128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0,
                 4'h1, 128'ha49c7ff2689f352b6b5bea43026a5049, "fips");
    endtask

    task automatic test_final_bypass();
        send_one(128'hd42711aee0bf98f1b8b45de51e415230, 128'h0, 1'b1,
                 4'h2, 128'hd4bf5d30e0b452aeb84111f11e2798e5, "bypass");
    endtask

    task automatic test_mixcol();
        logic [127:0] st;
        // Diagonal placement so ShiftRows gathers db,13,53,45 into column 0.
        st = '0;
        st[127:120] = 8'hdb;
        st[87:80]   = 8'h13;
        st[47:40]   = 8'h53;
        st[7:0]     = 8'h45;
        send_one(st, 128'h0, 1'b0, 4'h3, {32'h8e4da1bc, 96'h0}, "mixcol_diag");
        // Literal column-0 placement, checked against the model.
        st = {32'hdb135345, 96'h0};
        send_one(st, 128'h0, 1'b0, 4'h4, ref_round(st, 128'h0, 1'b0), "mixcol_col0");
    endtask

    task automatic test_backpressure();
        logic [127:0] s1, s2, s3, k1, e1;
        s1 = rand128(); s2 = rand128(); s3 = rand128(); k1 = rand128();
        e1 = ref_round(s1, k1, 1'b0);
        out_ready = 1'b0;
        in_key = k1; in_last = 1'b0;
        in_state = s1; in_tag = 4'h1; in_valid = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after1: got %b want 1", in_ready); end
        in_state = s2; in_tag = 4'h2;
        step();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after2: got %b want 0", in_ready); end
        in_state = s3; in_tag = 4'h3;
        step();
        step();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_stall: got %b want 0", in_ready); end
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'h1 || out_state !== e1) begin
            errors++;
            $display("FAIL bp_hold: got v=%b tag=%h state=%h want v=1 tag=1 state=%h", out_valid, out_tag, out_state, e1);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_tag !== 4'h2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain1: got tag=%h in_ready=%b want tag=2 in_ready=1", out_tag, in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'h3) begin
            errors++;
            $display("FAIL bp_tag3: got v=%b tag=%h want v=1 tag=3", out_valid, out_tag);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || sb_dat.size() != 0) begin
            errors++;
            $display("FAIL bp_empty: got v=%b pending=%0d want v=0 pending=0", out_valid, sb_dat.size());
        end
    endtask

    task automatic test_streaming();
        int           sent;
        int           cyc;
        logic         acc;
        logic         rdy_before;
        logic [127:0] cs, ck;
        logic         cl;
        sent = 0;
        cyc  = 0;
        cs = rand128(); ck = rand128(); cl = 1'($urandom_range(0, 1));
        while (sent < 16 && cyc < 300) begin
            in_state  = cs;
            in_key    = ck;
            in_last   = cl;
            in_tag    = 4'(sent);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 1));
            if (cyc == 6) begin
                rdy_before = in_ready;
                out_ready  = ~out_ready;
                #1;
                checks++;
                if (in_ready !== rdy_before) begin
                    errors++;
                    $display("FAIL stream_comb_path: in_ready got %b want %b after out_ready toggle", in_ready, rdy_before);
                end
            end
            acc = in_valid && in_ready;
            step();
            cyc++;
            if (acc) begin
                sent++;
                cs = rand128(); ck = rand128(); cl = 1'($urandom_range(0, 1));
            end
        end
        in_valid = 1'b0;
        checks++;
        if (sent != 16) begin errors++; $display("FAIL stream_timeout: sent %0d want 16", sent); end
        out_ready = 1'b1;
        cyc = 0;
        while (out_valid && cyc < 10) begin
            step();
            cyc++;
        end
        checks++;
        if (out_valid !== 1'b0 || sb_dat.size() != 0) begin
            errors++;
            $display("FAIL stream_drain: got v=%b pending=%0d want v=0 pending=0", out_valid, sb_dat.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] s5, k5;
        out_ready = 1'b0;
        in_key = rand128(); in_last = 1'b0;
        in_state = rand128(); in_tag = 4'h8; in_valid = 1'b1;
        step();
        in_state = rand128(); in_tag = 4'h9;
        step();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_full: in_ready got %b want 0", in_ready); end
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_state !== 128'h0 || out_tag !== 4'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_cleared: got v=%b state=%h tag=%h rdy=%b want v=0 state=0 tag=0 rdy=1",
                     out_valid, out_state, out_tag, in_ready);
        end
        s5 = rand128(); k5 = rand128();
        send_one(s5, k5, 1'b0, 4'h5, ref_round(s5, k5, 1'b0), "rmid_first");
    endtask

    initial begin
        test_reset();
        test_fips_round();
        test_final_bypass();
        test_mixcol();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        step();
        checks++;
        if (sb_dat.size() != 0) begin errors++; $display("FAIL final_pending: %0d outputs never seen, want 0", sb_dat.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
